// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port between NUM_REQ
// writeback sources. Define RF_WB_SCOREBOARD_EN to build the RAW busy-bit scoreboard.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic [5*NUM_REQ-1:0]  i_req_waddr,
    input  logic [32*NUM_REQ-1:0] i_req_wdata,
    output logic                  o_rd_wen,
    output logic [4:0]            o_rd_waddr,
    output logic [31:0]           o_rd_wdata,
    input  logic                  i_issue_valid,
    input  logic [4:0]            i_issue_rd,
    input  logic [4:0]            i_rs1_addr,
    input  logic [4:0]            i_rs2_addr,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy
);

    // Requester vectors are zero-padded to the maximum of four so a 2-bit index is always legal.
    logic [3:0]   valid_pad_s;
    logic [19:0]  waddr_pad_s;
    logic [127:0] wdata_pad_s;

    logic [1:0]   ptr_r;
    logic [1:0]   ptr_nxt_s;
    logic [2:0]   cand_s;
    logic         gnt_any_s;
    logic [1:0]   gnt_idx_s;
    logic [3:0]   gnt_onehot_s;
    logic [4:0]   sel_waddr_s;
    logic [31:0]  sel_wdata_s;

    logic         wen_r;
    logic [4:0]   waddr_r;
    logic [31:0]  wdata_r;

    assign valid_pad_s = 4'(i_req_valid);
    assign waddr_pad_s = 20'(i_req_waddr);
    assign wdata_pad_s = 128'(i_req_wdata);

    // Scan requesters starting at ptr, wrapping modulo NUM_REQ; first valid one wins.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = 2'd0;
        cand_s    = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = {1'b0, ptr_r} + 3'(i);
            if (cand_s >= 3'(NUM_REQ)) begin
                cand_s = cand_s - 3'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_any_s && valid_pad_s[cand_s[1:0]]) begin
                gnt_any_s = 1'b1;
                gnt_idx_s = cand_s[1:0];
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    // Pointer moves just past the winner; it holds when nobody requests.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (gnt_any_s) begin
            if ({1'b0, gnt_idx_s} == 3'(NUM_REQ - 1)) begin
                ptr_nxt_s = 2'd0;
            end else begin
                ptr_nxt_s = gnt_idx_s + 2'd1;
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    assign gnt_onehot_s = gnt_any_s ? (4'd1 << gnt_idx_s) : 4'd0;
    assign o_req_ready  = gnt_onehot_s[NUM_REQ-1:0] & {NUM_REQ{i_rst_n}};
    assign sel_waddr_s  = waddr_pad_s[({3'd0, gnt_idx_s} * 5'd5) +: 5];
    assign sel_wdata_s  = wdata_pad_s[({5'd0, gnt_idx_s} * 7'd32) +: 32];

    // Arbitration pointer and registered rf write port; x0 writes drain with wen low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_r   <= 2'd0;
            wen_r   <= 1'b0;
            waddr_r <= 5'd0;
            wdata_r <= 32'd0;
        end else begin
            ptr_r <= ptr_nxt_s;
            if (gnt_any_s) begin
                wen_r   <= (sel_waddr_s != 5'd0);
                waddr_r <= sel_waddr_s;
                wdata_r <= sel_wdata_s;
            end else begin
                wen_r <= 1'b0;
            end
        end
    end

    assign o_rd_wen   = wen_r;
    assign o_rd_waddr = waddr_r;
    assign o_rd_wdata = wdata_r;

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] busy_r;
    logic [31:0] busy_set_s;
    logic [31:0] busy_clr_s;
    logic [31:0] busy_nxt_s;

    // The clear follows the committing write; a same-edge issue re-reserves and wins.
    always_comb begin
        busy_set_s = 32'd0;
        busy_clr_s = 32'd0;
        if (i_issue_valid) begin
            busy_set_s[i_issue_rd] = 1'b1;
        end else begin
            busy_set_s = 32'd0;
        end
        if (wen_r) begin
            busy_clr_s[waddr_r] = 1'b1;
        end else begin
            busy_clr_s = 32'd0;
        end
        busy_nxt_s = ((busy_r & ~busy_clr_s) | busy_set_s) & 32'hFFFF_FFFE;
    end

    // Busy-bit storage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign o_rs1_busy = busy_r[i_rs1_addr];
    assign o_rs2_busy = busy_r[i_rs2_addr];
`else
    logic unused_s;

    assign unused_s   = ^{i_issue_valid, i_issue_rd, i_rs1_addr, i_rs2_addr};
    assign o_rs1_busy = 1'b0;
    assign o_rs2_busy = 1'b0;
`endif

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the single synchronous register-file write port between up to four writeback sources: ALU, load unit, mul/div and CSR. It grants round-robin, one write per cycle, and registers the winning write onto the `rf` write port. An optional scoreboard tracks destination registers with outstanding writes, so decode can stall on RAW hazards against multi-cycle units.

## Interface
- `NUM_REQ`, default 2: number of writeback requesters. Legal values are 2..4.
- `i_clk`  in  1: global clock. All state updates on the rising edge.
- `i_rst_n`  in  1: reset, asynchronous assert, active-low.
- `i_req_valid`  in  NUM_REQ: per-requester write request.
- `o_req_ready`  out  NUM_REQ: per-requester grant. Combinational; one-hot or zero.
- `i_req_waddr`  in  5*NUM_REQ: packed destination addresses. Requester k is at bits [5k+4:5k].
- `i_req_wdata`  in  32*NUM_REQ: packed write data. Requester k is at bits [32k+31:32k].
- `o_rd_wen`  out  1: to `rf` `i_rd_wen`. Registered.
- `o_rd_waddr`  out  5: to `rf` `i_rd_waddr`. Registered.
- `o_rd_wdata`  out  32: to `rf` `i_rd_wdata`. Registered.
- `i_issue_valid`  in  1: decode issues an instruction that writes `i_issue_rd`.
- `i_issue_rd`  in  5: destination register being reserved.
- `i_rs1_addr`, `i_rs2_addr`  in  5 each: scoreboard lookup addresses.
- `o_rs1_busy`, `o_rs2_busy`  out  1 each: lookup results. Combinational.

## Operation
- **Handshake.** A transfer occurs on a cycle where `i_req_valid[k]` and `o_req_ready[k]` are both high.
  - Requester k holds valid, waddr and wdata stable until the transfer.
  - `o_req_ready[k]` may only be high when `i_req_valid[k]` is high.
- **Arbitration.** A priority pointer `ptr` (0..NUM_REQ-1) selects the first requester to consider.
  - The grant goes to the first valid requester scanning ptr, ptr+1, … modulo NUM_REQ.
  - After granting requester g, `ptr` takes (g+1) mod NUM_REQ on the next edge.
  - With no valid requester, `ptr` holds.
- **Output stage.** On the edge of a transfer from requester g:
  - `o_rd_waddr` and `o_rd_wdata` load requester g's address and data.
  - `o_rd_wen` loads 1, unless the address is 0.
  - With no transfer, `o_rd_wen` loads 0 and the address/data registers hold.
- **Writes to x0.** A request with address 0 is still granted, so the requester drains. It advances `ptr`, but produces `o_rd_wen`=0 and touches no scoreboard state.
- **Scoreboard.** Holds 32 busy bits; bit 0 is constant 0.
  - Set: an edge with `i_issue_valid` and `i_issue_rd`≠0 sets `busy[i_issue_rd]`.
  - Clear: the edge that ends a cycle with `o_rd_wen`=1 clears `busy[o_rd_waddr]`. At that point the data is committed in `rf`, so the clear is correct for either `BYPASS_EN` setting.
  - Simultaneous set and clear of the same bit: the set wins.
  - Lookup: `o_rsN_busy` = `busy[i_rsN_addr]`; the result is 0 for address 0.
- **Protocol rule.** Decode must not issue to an rd whose busy bit is set (WAW). Decode stalls on a lookup of its own rd. Behaviour on violation is undefined; the bench flags it with an assertion.

## Timing
- **Reset.** While `i_rst_n`=0:
  - `o_rd_wen`=0, `o_rd_waddr`=0, `o_rd_wdata`=0.
  - `ptr`=0 and all busy bits are 0.
  - `o_req_ready`=0 regardless of requests.
- **Reset mid-operation.** Any registered, uncommitted write is dropped; requesters keep valid asserted. Arbitration restarts at `ptr`=0 on the first edge after deassertion.
- **Latency.**
  - A transfer at edge N drives the `rf` write port during cycle N..N+1.
  - The value is readable from `rf` after edge N+1 without bypass, or during cycle N..N+1 with bypass.
  - The busy bit falls at edge N+1.
- **Throughput.** One write per cycle, sustained.
- **Fairness.** A continuously valid requester waits at most NUM_REQ-1 cycles.
- **Combinational paths.**
  - `i_req_valid` → `o_req_ready`.
  - `i_rsN_addr` → `o_rsN_busy`.
  - No combinational path from requester data to the `rf` port.

## Configuration
- `RF_WB_SCOREBOARD_EN` defined: busy bits, issue port and lookup outputs operate as above.
- `RF_WB_SCOREBOARD_EN` undefined: the busy array is not instantiated, `i_issue_*` is ignored, and `o_rs1_busy`/`o_rs2_busy` are tied to 0. Arbitration and the output stage are unchanged.

## Test plan
- **Reset, then solo request.** Reset asserted asynchronously mid-cycle; all outputs read 0 immediately. After release, only requester 1 valid with x5/0xDEADBEEF: `o_req_ready`=2'b10 that cycle; next cycle `o_rd_wen`=1, `o_rd_waddr`=5, `o_rd_wdata`=0xDEADBEEF.
- **Round-robin.** NUM_REQ=3, all three valid for 6 cycles: grants go 0,1,2,0,1,2 and `o_rd_wen` is high for 6 consecutive cycles.
- **x0 request.** Requester 0 valid with x0/0x12345678: it is granted and the next cycle shows `o_rd_wen`=0. Then `ptr`=1: with both valid, requester 1 wins.
- **Scoreboard clear timing** (macro on). Issue rd=7 at edge 0: `o_rs1_busy`=1 for `i_rs1_addr`=7 from cycle 1. Requester writes x7 at edge 3: busy stays 1 through cycle 3..4 and reads 0 after edge 4.
- **Scoreboard set/clear collision** (macro on). Write to x9 committing on the same edge as an issue to x9: busy[9] reads 1 afterwards. A lookup of x0 reads 0 at all times.
- **Scoreboard compiled out** (macro off). Rerun the collision test: busy outputs stay 0 and write-port traffic is identical to the macro-on run.
